// File: rtl/mvu_pkg.sv
// rtl/mvu_pkg.sv - shared types for the MVU CSR APB master
package mvu_pkg;

  localparam int CSR_OFFSET_W = 12;
  localparam int MVU_BMVUA    = 3;
  localparam int MVU_DATA_W   = 32;

  typedef struct packed {
    logic                    write;
    logic [MVU_BMVUA-1:0]    mvu_id;
    logic [CSR_OFFSET_W-1:0] csr;
    logic [MVU_DATA_W-1:0]   wdata;
  } csr_req_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_t;

endpackage

// File: rtl/csr_req_fifo.sv
// rtl/csr_req_fifo.sv - request FIFO of csr_req_t with full/empty flags
module csr_req_fifo
  import mvu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  csr_req_t push_data_i,
  input  logic     pop_i,
  output csr_req_t pop_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  csr_req_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            wr_en;
  logic            rd_en;

  assign full_o     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o    = (count_q == '0);
  assign wr_en      = push_i && !full_o;
  assign rd_en      = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mvu_csr_apb_master.sv
// rtl/mvu_csr_apb_master.sv - queued CSR requests issued as APB transfers to the MVU slave
module mvu_csr_apb_master
  import mvu_pkg::*;
#(
  parameter int BMVUA          = 3,
  parameter int APB_ADDR_WIDTH = BMVUA + 12,
  parameter int DATA_W         = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [BMVUA-1:0]          req_mvu_id,
  input  logic [CSR_OFFSET_W-1:0]   req_csr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  // Counter only needs to reach TIMEOUT-1; the abort fires on that cycle.
  localparam int           TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_mst_state_t            state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                      pwrite_q, pwrite_d;
  logic [DATA_W-1:0]         pwdata_q, pwdata_d;
  logic [DATA_W-1:0]         rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [TW-1:0]             tmo_q, tmo_d;

  csr_req_t push_req;
  csr_req_t head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_pop;
  logic     load;

  assign push_req.write  = req_write;
  assign push_req.mvu_id = req_mvu_id;
  assign push_req.csr    = req_csr;
  assign push_req.wdata  = req_wdata;

  csr_req_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (req_valid),
    .push_data_i(push_req),
    .pop_i      (fifo_pop),
    .pop_data_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tmo_d       = tmo_q;
    fifo_pop    = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        tmo_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_err_d   = pslverr;
          rsp_rdata_d = (pwrite_q || pslverr) ? '0 : prdata;
          state_d     = RESP;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        // Skipping IDLE keeps throughput at 3 cycles; RESP already gives the psel gap.
        if (rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            load     = 1'b1;
            state_d  = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      paddr_d  = APB_ADDR_WIDTH'({head.mvu_id, head.csr});
      pwrite_d = head.write;
      pwdata_d = DATA_W'(head.wdata);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tmo_q       <= tmo_d;
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign req_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_mvu_csr_apb_master.sv
// tb/tb_mvu_csr_apb_master.sv - self-checking bench for mvu_csr_apb_master
module tb_mvu_csr_apb_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_mvu_id;
  logic [11:0] req_csr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [14:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  always #5 clk = ~clk;

  mvu_csr_apb_master #(
    .BMVUA(3), .APB_ADDR_WIDTH(15), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_mvu_id(req_mvu_id), .req_csr(req_csr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic        write;
    logic [2:0]  id;
    logic [11:0] csr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic        hang;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // APB slave model and response scoreboard, both acting on the falling edge.
  initial begin
    vec_t cur;
    logic prev_psel = 1'b0;
    logic in_acc    = 1'b0;
    int   acc_cnt   = 0;
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    cur     = '{1'b0, 3'd0, 12'd0, 32'd0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_psel = 1'b0;
        in_acc    = 1'b0;
        acc_cnt   = 0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
      end else begin
        if (psel && !penable) begin
          chk("psel_gap", prev_psel, 1'b0);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL setup_unexpected actual=transfer required=none");
          end else begin
            cur = exp_q[0];
            chk("paddr", paddr, {cur.id, cur.csr});
            chk("pwrite", pwrite, cur.write);
            if (cur.write) chk("pwdata", pwdata, cur.wdata);
          end
          acc_cnt = 0;
        end
        if (psel && penable) begin
          in_acc  = 1'b1;
          acc_cnt++;
          pready  = !cur.hang && (acc_cnt == cur.waits + 1);
          prdata  = cur.prdata;
          pslverr = pready ? cur.slverr : 1'b1;
        end else begin
          pready  = 1'b0;
          pslverr = 1'b0;
          prdata  = '0;
          if (in_acc) begin
            chk("access_cycles", acc_cnt, cur.hang ? TMO : cur.waits + 1);
            in_acc = 1'b0;
          end
        end
        if (rsp_valid && rsp_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected actual=response required=none");
          end else begin
            chk("rsp_rdata", rsp_rdata, exp_q[0].exp_rdata);
            chk("rsp_err", rsp_err, exp_q[0].exp_err);
            void'(exp_q.pop_front());
          end
        end
        prev_psel = psel;
      end
    end
  end

  task automatic push(input vec_t v);
    int n = 0;
    req_write  = v.write;
    req_mvu_id = v.id;
    req_csr    = v.csr;
    req_wdata  = v.wdata;
    req_valid  = 1'b1;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL push_wait actual=blocked required=accepted");
      req_valid = 1'b0;
    end else begin
      exp_q.push_back(v);
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", (exp_q.size() == 0 && !busy), 1'b1);
  endtask

  task automatic latency_seq();
    vec_t v;
    v = '{1'b1, 3'd2, 12'h020, 32'h0000DEAD, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    chk("lat_req_ready", req_ready, 1'b1);
    req_write = 1'b1; req_mvu_id = 3'd2; req_csr = 12'h020; req_wdata = 32'h0000DEAD;
    req_valid = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("lat_T_psel", psel, 1'b0);
    @(posedge clk); #1;
    chk("lat_T1_psel", psel, 1'b1);
    chk("lat_T1_penable", penable, 1'b0);
    chk("lat_T1_paddr", paddr, 15'h2020);
    @(posedge clk); #1;
    chk("lat_T2_psel", psel, 1'b1);
    chk("lat_T2_penable", penable, 1'b1);
    chk("lat_T2_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_T3_rsp_valid", rsp_valid, 1'b1);
    chk("lat_T3_psel", psel, 1'b0);
    chk("lat_T3_rsp_err", rsp_err, 1'b0);
    chk("lat_T3_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    chk("lat_done_busy", busy, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    vecs[0] = '{1'b1, 3'd1, 12'h004, 32'h00000001, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 3'd2, 12'h010, 32'h0,        3, 32'h00001234, 1'b0, 1'b0, 32'h00001234, 1'b0};
    vecs[2] = '{1'b0, 3'd7, 12'hFFF, 32'h0,        0, 32'hA5A55A5A, 1'b0, 1'b0, 32'hA5A55A5A, 1'b0};
    vecs[3] = '{1'b0, 3'd0, 12'h000, 32'h0,        1, 32'h00000077, 1'b1, 1'b0, 32'h00000000, 1'b1};
    vecs[4] = '{1'b1, 3'd3, 12'h123, 32'hCAFEBABE, 2, 32'h0,        1'b1, 1'b0, 32'h00000000, 1'b1};
    vecs[5] = '{1'b0, 3'd4, 12'h040, 32'h0,        0, 32'h0000BEEF, 1'b0, 1'b1, 32'h00000000, 1'b1};
    vecs[6] = '{1'b0, 3'd5, 12'h080, 32'h0,        7, 32'h0BADF00D, 1'b0, 1'b0, 32'h0BADF00D, 1'b0};
    vecs[7] = '{1'b1, 3'd6, 12'h800, 32'h0,        0, 32'h12345678, 1'b0, 1'b0, 32'h00000000, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_mvu_id = '0;
    req_csr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_paddr", paddr, 15'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_req_ready", req_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    latency_seq();

    for (int i = 0; i < 8; i++) push(vecs[i]);
    wait_drain(2000);

    // Fill: first request parks in RESP, the next four fill the FIFO.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = '{1'b1, 3'(i), 12'(16 * i), 32'(100 + i), 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      push(v);
    end
    chk("full_req_ready", req_ready, 1'b0);
    chk("full_busy", busy, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("full_req_ready_hold", req_ready, 1'b0);
    rsp_ready = 1'b1;
    wait_drain(500);

    // Error response held under rsp_ready backpressure.
    rsp_ready = 1'b0;
    v = '{1'b0, 3'd1, 12'h0C0, 32'h0, 1, 32'h0000CAFE, 1'b1, 1'b0, 32'h0, 1'b1};
    push(v);
    v = '{1'b0, 3'd2, 12'h0C4, 32'h0, 0, 32'h000055AA, 1'b0, 1'b0, 32'h000055AA, 1'b0};
    push(v);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_rsp_seen", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", rsp_valid, 1'b1);
      chk("stall_rsp_err", rsp_err, 1'b1);
      chk("stall_psel", psel, 1'b0);
    end
    rsp_ready = 1'b1;
    wait_drain(200);

    // Reset in the middle of an ACCESS that the slave never completes.
    v = '{1'b0, 3'd3, 12'h100, 32'h0, 0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    push(v);
    v = '{1'b1, 3'd4, 12'h104, 32'h11, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    push(v);
    n = 0;
    while (!penable && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_penable", penable, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_psel", psel, 1'b0);
    chk("mid_rst_penable", penable, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    latency_seq();
    wait_drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
